// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit with sub-word read-modify-write to a word-addressed data memory
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        LSU_req_valid,
  output logic        LSU_req_ready,
  input  logic        LSU_we,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_unsigned,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic        LSU_done,
  output logic        LSU_fault,
  output logic [31:0] LSU_rdata,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  typedef enum logic [0:0] {IDLE, RMW_WR} state_e;

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           merged_q, merged_d;

  logic                  accept;
  logic                  addr_fault;
  logic                  req_fault;
  logic                  is_sub_store;
  logic [1:0]            byte_lane;
  logic                  half_lane;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_value;
  logic [31:0]           merged_word;

  assign LSU_req_ready = (state_q == IDLE);
  assign accept        = LSU_req_valid & LSU_req_ready;
  assign req_idx       = LSU_addr[ADDR_WIDTH+1:2];
  assign addr_fault    = |LSU_addr[31:ADDR_WIDTH+2];
  // size=11 has bit 1 set, so it never reaches the RMW path even before the fault check
  assign is_sub_store  = LSU_we & ~LSU_size[1];
  assign byte_lane     = BIG_ENDIAN ? (2'd3 - LSU_addr[1:0]) : LSU_addr[1:0];
  assign half_lane     = BIG_ENDIAN ? ~LSU_addr[1] : LSU_addr[1];

  always_comb begin
    req_fault = 1'b1;
    case (LSU_size)
      2'b00:   req_fault = addr_fault;
      2'b01:   req_fault = addr_fault | LSU_addr[0];
      2'b10:   req_fault = addr_fault | (|LSU_addr[1:0]);
      default: req_fault = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = DMEM_data_out[7:0];
    case (byte_lane)
      2'd0:    ld_byte = DMEM_data_out[7:0];
      2'd1:    ld_byte = DMEM_data_out[15:8];
      2'd2:    ld_byte = DMEM_data_out[23:16];
      default: ld_byte = DMEM_data_out[31:24];
    endcase
    ld_half = half_lane ? DMEM_data_out[31:16] : DMEM_data_out[15:0];

    ld_value = DMEM_data_out;
    case (LSU_size)
      2'b00:   ld_value = LSU_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_value = LSU_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_value = DMEM_data_out;
    endcase

    merged_word = DMEM_data_out;
    if (LSU_size == 2'b00) begin
      case (byte_lane)
        2'd0:    merged_word[7:0]   = LSU_wdata[7:0];
        2'd1:    merged_word[15:8]  = LSU_wdata[7:0];
        2'd2:    merged_word[23:16] = LSU_wdata[7:0];
        default: merged_word[31:24] = LSU_wdata[7:0];
      endcase
    end else if (half_lane) begin
      merged_word[31:16] = LSU_wdata[15:0];
    end else begin
      merged_word[15:0] = LSU_wdata[15:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    fault_d        = 1'b0;
    rdata_d        = rdata_q;
    idx_d          = idx_q;
    merged_d       = merged_q;
    DMEM_address   = '0;
    DMEM_data_in   = '0;
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          if (req_fault) begin
            fault_d = 1'b1;
          end else if (!LSU_we) begin
            DMEM_mem_read = 1'b1;
            DMEM_address  = {{(32-ADDR_WIDTH){1'b0}}, req_idx};
            rdata_d       = ld_value;
          end else if (is_sub_store) begin
            DMEM_mem_read = 1'b1;
            DMEM_address  = {{(32-ADDR_WIDTH){1'b0}}, req_idx};
            idx_d         = req_idx;
            merged_d      = merged_word;
            state_d       = RMW_WR;
            done_d        = 1'b0;
          end else begin
            DMEM_mem_write = 1'b1;
            DMEM_address   = {{(32-ADDR_WIDTH){1'b0}}, req_idx};
            DMEM_data_in   = LSU_wdata;
          end
        end
      end
      RMW_WR: begin
        DMEM_mem_write = 1'b1;
        DMEM_address   = {{(32-ADDR_WIDTH){1'b0}}, idx_q};
        DMEM_data_in   = merged_q;
        state_d        = IDLE;
        done_d         = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Reset must kill an in-flight RMW write before the memory's negedge sample
    if (SYS_reset) begin
      DMEM_address   = '0;
      DMEM_data_in   = '0;
      DMEM_mem_write = 1'b0;
      DMEM_mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      idx_q    <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
      merged_q <= merged_d;
    end
  end

  assign LSU_done  = done_q;
  assign LSU_fault = fault_q;
  assign LSU_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - testbench for lsu_mem_ctrl, little- and big-endian instances side by side
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        SYS_reset;
  logic        req_valid, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy_le, done_le, fault_le, mwr_le, mrd_le;
  logic [31:0] rdata_le, daddr_le, din_le, dout_le;
  logic        rdy_be, done_be, fault_be, mwr_be, mrd_be;
  logic [31:0] rdata_be, daddr_be, din_be, dout_be;

  logic [31:0] mem_le [0:255];
  logic [31:0] mem_be [0:255];
  logic [31:0] ref_le [0:255];
  logic [31:0] ref_be [0:255];
  logic [31:0] exp_rd_le, exp_rd_be;

  int          vectors = 0;
  int          errs    = 0;

  int          obs_lat;
  logic        obs_rdy_after, obs_done_be, obs_fault_le, obs_fault_be;
  logic [31:0] obs_addr, obs_din, obs_rd_le, obs_rd_be;
  logic [3:0]  obs_strobe;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .SYS_reset(SYS_reset), .LSU_req_valid(req_valid), .LSU_req_ready(rdy_le),
    .LSU_we(req_we), .LSU_size(req_size), .LSU_unsigned(req_uns), .LSU_addr(req_addr),
    .LSU_wdata(req_wdata), .LSU_done(done_le), .LSU_fault(fault_le), .LSU_rdata(rdata_le),
    .DMEM_address(daddr_le), .DMEM_data_in(din_le), .DMEM_mem_write(mwr_le),
    .DMEM_mem_read(mrd_le), .DMEM_data_out(dout_le));

  lsu_mem_ctrl #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .SYS_reset(SYS_reset), .LSU_req_valid(req_valid), .LSU_req_ready(rdy_be),
    .LSU_we(req_we), .LSU_size(req_size), .LSU_unsigned(req_uns), .LSU_addr(req_addr),
    .LSU_wdata(req_wdata), .LSU_done(done_be), .LSU_fault(fault_be), .LSU_rdata(rdata_be),
    .DMEM_address(daddr_be), .DMEM_data_in(din_be), .DMEM_mem_write(mwr_be),
    .DMEM_mem_read(mrd_be), .DMEM_data_out(dout_be));

  function automatic logic [31:0] image(input int i);
    return 32'h3C5A_0000 + 32'(i) * 32'h0001_0107;
  endfunction

  always @(negedge clk) begin
    if (SYS_reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_le[i] <= image(i);
        mem_be[i] <= image(i);
      end
    end else begin
      if (mwr_le) mem_le[daddr_le[7:0]] <= din_le;
      if (mwr_be) mem_be[daddr_be[7:0]] <= din_be;
    end
  end

  assign dout_le = mem_le[daddr_le[7:0]];
  assign dout_be = mem_be[daddr_be[7:0]];

  // Reference model: byte offset of the lane's least-significant byte within the word
  function automatic int lane_off(input bit be, input logic [1:0] sz, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    if (!be) return o;
    if (sz == 2'd0) return 3 - o;
    return 2 - o;
  endfunction

  function automatic bit mdl_fault(input logic [1:0] sz, input logic [31:0] a);
    if (a >= 32'h400) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input bit be, input logic [31:0] word,
                                           input logic [1:0] sz, input bit u, input logic [31:0] a);
    int nb, sh;
    logic [31:0] mask, v;
    if (sz == 2'd2) return word;
    nb   = (sz == 2'd0) ? 1 : 2;
    sh   = 8 * lane_off(be, sz, a);
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = (word >> sh) & mask;
    if (!u && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input bit be, input logic [31:0] old,
                                            input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] d);
    int nb, sh;
    logic [31:0] mask;
    if (sz == 2'd2) return d;
    nb   = (sz == 2'd0) ? 1 : 2;
    sh   = 8 * lane_off(be, sz, a);
    mask = (32'd1 << (8 * nb)) - 32'd1;
    return (old & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  task automatic reload_ref();
    for (int i = 0; i < 256; i++) begin
      ref_le[i] = image(i);
      ref_be[i] = image(i);
    end
    exp_rd_le = '0;
    exp_rd_be = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the completion cycle
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_we = w; req_size = sz; req_uns = u; req_addr = a; req_wdata = d;
    #1;
    n = 0;
    while (!rdy_le && n < 20) begin @(posedge clk); #2; n++; end
    obs_addr   = daddr_le;
    obs_din    = din_le;
    obs_strobe = {mwr_le, mrd_le, mwr_be, mrd_be};
    @(posedge clk); #1;
    req_valid     = 1'b0;
    obs_rdy_after = rdy_le;
    n = 1;
    while (!done_le && n < 10) begin @(posedge clk); #1; n++; end
    obs_lat      = n;
    obs_done_be  = done_be;
    obs_fault_le = fault_le;
    obs_fault_be = fault_be;
    obs_rd_le    = rdata_le;
    obs_rd_be    = rdata_be;
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    #12;
    vectors++; if ({mwr_le, mrd_le, mwr_be, mrd_be} !== 4'b0) begin errs++; $display("FAIL reset_strobes: got %b want 0000", {mwr_le, mrd_le, mwr_be, mrd_be}); end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 SYS_reset = 1'b0;
    reload_ref();
    #1;
    vectors++; if (done_le !== 1'b0 || done_be !== 1'b0) begin errs++; $display("FAIL reset_done: got %b%b want 00", done_le, done_be); end
    vectors++; if (fault_le !== 1'b0) begin errs++; $display("FAIL reset_fault: got %b want 0", fault_le); end
    vectors++; if (rdata_le !== 32'h0 || rdata_be !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h/%h want 0", rdata_le, rdata_be); end
    vectors++; if (rdy_le !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", rdy_le); end
    vectors++; if (daddr_le !== 32'h0 || din_le !== 32'h0) begin errs++; $display("FAIL reset_idle_bus: got %h/%h want 0", daddr_le, din_le); end
    vectors++; if (mem_le[7] !== image(7)) begin errs++; $display("FAIL reset_image: got %h want %h", mem_le[7], image(7)); end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hA1B2C3D4);
    ref_le[4] = 32'hA1B2C3D4; ref_be[4] = 32'hA1B2C3D4;
    vectors++; if (obs_lat !== 1) begin errs++; $display("FAIL sw_latency: got %0d want 1", obs_lat); end
    vectors++; if (obs_addr !== 32'd4) begin errs++; $display("FAIL sw_address: got %h want 4", obs_addr); end
    vectors++; if (obs_strobe !== 4'b1010) begin errs++; $display("FAIL sw_strobe: got %b want 1010", obs_strobe); end
    vectors++; if (obs_din !== 32'hA1B2C3D4) begin errs++; $display("FAIL sw_data_in: got %h want a1b2c3d4", obs_din); end
    vectors++; if (obs_rdy_after !== 1'b1) begin errs++; $display("FAIL sw_ready: got %b want 1", obs_rdy_after); end
    vectors++; if (mem_le[4] !== 32'hA1B2C3D4) begin errs++; $display("FAIL sw_mem: got %h want a1b2c3d4", mem_le[4]); end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    exp_rd_le = 32'hA1B2C3D4; exp_rd_be = 32'hA1B2C3D4;
    vectors++; if (obs_lat !== 1) begin errs++; $display("FAIL lw_latency: got %0d want 1", obs_lat); end
    vectors++; if (obs_addr !== 32'd4) begin errs++; $display("FAIL lw_address: got %h want 4", obs_addr); end
    vectors++; if (obs_rd_le !== 32'hA1B2C3D4 || obs_rd_be !== 32'hA1B2C3D4) begin errs++; $display("FAIL lw_rdata: got %h/%h want a1b2c3d4", obs_rd_le, obs_rd_be); end
  endtask

  task automatic test_sub_word();
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456EE);
    ref_le[4] = 32'hA1B2EED4; ref_be[4] = 32'hA1EEC3D4;
    vectors++; if (obs_lat !== 2) begin errs++; $display("FAIL sb_latency: got %0d want 2", obs_lat); end
    vectors++; if (obs_rdy_after !== 1'b0) begin errs++; $display("FAIL sb_ready_low: got %b want 0", obs_rdy_after); end
    vectors++; if (obs_strobe !== 4'b0101) begin errs++; $display("FAIL sb_read_strobe: got %b want 0101", obs_strobe); end
    vectors++; if (mem_le[4] !== 32'hA1B2EED4) begin errs++; $display("FAIL sb_mem_le: got %h want a1b2eed4", mem_le[4]); end
    vectors++; if (mem_be[4] !== 32'hA1EEC3D4) begin errs++; $display("FAIL sb_mem_be: got %h want a1eec3d4", mem_be[4]); end
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    exp_rd_le = 32'hFFFFFFEE; exp_rd_be = 32'hFFFFFFEE;
    vectors++; if (obs_rd_le !== 32'hFFFFFFEE || obs_rd_be !== 32'hFFFFFFEE) begin errs++; $display("FAIL lb_rdata: got %h/%h want ffffffee", obs_rd_le, obs_rd_be); end
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    exp_rd_le = 32'h000000EE; exp_rd_be = 32'h000000EE;
    vectors++; if (obs_rd_le !== 32'h000000EE || obs_rd_be !== 32'h000000EE) begin errs++; $display("FAIL lbu_rdata: got %h/%h want 000000ee", obs_rd_le, obs_rd_be); end
  endtask

  task automatic test_big_endian();
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);
    ref_le[0] = 32'h11223344; ref_be[0] = 32'h11223344;
    issue(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
    exp_rd_le = 32'h00001122; exp_rd_be = 32'h00003344;
    vectors++; if (obs_rd_be !== 32'h00003344) begin errs++; $display("FAIL be_lh_rdata: got %h want 00003344", obs_rd_be); end
    vectors++; if (obs_rd_le !== 32'h00001122) begin errs++; $display("FAIL le_lh_rdata: got %h want 00001122", obs_rd_le); end
    issue(1'b1, 2'd1, 1'b0, 32'h0, 32'hABCD8899);
    ref_le[0] = 32'h11228899; ref_be[0] = 32'h88993344;
    vectors++; if (obs_lat !== 2) begin errs++; $display("FAIL sh_latency: got %0d want 2", obs_lat); end
    vectors++; if (mem_be[0] !== 32'h88993344) begin errs++; $display("FAIL be_sh_mem: got %h want 88993344", mem_be[0]); end
    vectors++; if (mem_le[0] !== 32'h11228899) begin errs++; $display("FAIL le_sh_mem: got %h want 11228899", mem_le[0]); end
    issue(1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    exp_rd_le = 32'hFFFF8899; exp_rd_be = 32'hFFFF8899;
    vectors++; if (obs_rd_le !== 32'hFFFF8899 || obs_rd_be !== 32'hFFFF8899) begin errs++; $display("FAIL lh_sign: got %h/%h want ffff8899", obs_rd_le, obs_rd_be); end
  endtask

  task automatic test_faults();
    logic [31:0] f_addr [5];
    logic [1:0]  f_size [5];
    logic        f_we   [5];
    logic [7:0]  widx;
    f_addr = '{32'h13, 32'h13, 32'h400, 32'h8, 32'h402};
    f_size = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
    f_we   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      issue(f_we[k], f_size[k], 1'b0, f_addr[k], 32'hDEADBEEF);
      widx = f_addr[k][9:2];
      vectors++; if (obs_fault_le !== 1'b1 || obs_fault_be !== 1'b1) begin errs++; $display("FAIL fault_flag[%0d]: got %b%b want 11", k, obs_fault_le, obs_fault_be); end
      vectors++; if (obs_lat !== 1) begin errs++; $display("FAIL fault_latency[%0d]: got %0d want 1", k, obs_lat); end
      vectors++; if (obs_strobe !== 4'b0) begin errs++; $display("FAIL fault_strobe[%0d]: got %b want 0000", k, obs_strobe); end
      vectors++; if (obs_rd_le !== exp_rd_le || obs_rd_be !== exp_rd_be) begin errs++; $display("FAIL fault_rdata[%0d]: got %h/%h want %h/%h", k, obs_rd_le, obs_rd_be, exp_rd_le, exp_rd_be); end
      vectors++; if (mem_le[widx] !== ref_le[widx]) begin errs++; $display("FAIL fault_mem[%0d]: got %h want %h", k, mem_le[widx], ref_le[widx]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_addr [4];
    logic        b_we   [4];
    logic [1:0]  b_size [4];
    logic [9:0]  acc_mask, done_mask;
    logic        acc;
    int          k;
    b_addr = '{32'h20, 32'h24, 32'h21, 32'h20};
    b_we   = '{1'b0, 1'b0, 1'b1, 1'b0};
    b_size = '{2'd2, 2'd2, 2'd0, 2'd2};
    ref_le[8] = mdl_store(1'b0, ref_le[8], 2'd0, 32'h21, 32'h5A);
    ref_be[8] = mdl_store(1'b1, ref_be[8], 2'd0, 32'h21, 32'h5A);
    acc_mask = '0; done_mask = '0; k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 4) begin
        req_valid = 1'b1; req_we = b_we[k]; req_size = b_size[k];
        req_uns = 1'b0; req_addr = b_addr[k]; req_wdata = 32'h5A;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      acc = req_valid & rdy_le;
      if (acc) acc_mask[c] = 1'b1;
      @(posedge clk); #1;
      if (done_le) done_mask[c+1] = 1'b1;
      if (acc) k++;
    end
    req_valid = 1'b0;
    exp_rd_le = ref_le[8]; exp_rd_be = ref_be[8];
    vectors++; if (acc_mask !== 10'b00_0001_0111) begin errs++; $display("FAIL b2b_accepts: got %b want 0000010111", acc_mask); end
    vectors++; if (done_mask !== 10'b00_0011_0110) begin errs++; $display("FAIL b2b_dones: got %b want 0000110110", done_mask); end
    vectors++; if (rdata_le !== exp_rd_le || rdata_be !== exp_rd_be) begin errs++; $display("FAIL b2b_rdata: got %h/%h want %h/%h", rdata_le, rdata_be, exp_rd_le, exp_rd_be); end
  endtask

  task automatic test_random();
    logic        w, u, flt;
    logic [1:0]  sz;
    logic [31:0] a, d;
    logic [7:0]  widx;
    logic [3:0]  exp_strobe;
    int          exp_lat;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      d  = $urandom;
      case ($urandom_range(0, 7))
        0:       a = 32'h400 + $urandom_range(0, 1023);
        1:       a = $urandom_range(1016, 1023);
        default: a = $urandom_range(0, 127);
      endcase
      flt  = mdl_fault(sz, a);
      widx = a[9:2];
      exp_lat    = (!flt && w && sz != 2'd2) ? 2 : 1;
      exp_strobe = flt ? 4'b0000 : (w && sz == 2'd2) ? 4'b1010 : 4'b0101;
      if (!flt && !w) begin
        exp_rd_le = mdl_load(1'b0, ref_le[widx], sz, u, a);
        exp_rd_be = mdl_load(1'b1, ref_be[widx], sz, u, a);
      end else if (!flt) begin
        ref_le[widx] = mdl_store(1'b0, ref_le[widx], sz, a, d);
        ref_be[widx] = mdl_store(1'b1, ref_be[widx], sz, a, d);
      end
      issue(w, sz, u, a, d);
      vectors++; if (obs_lat !== exp_lat || obs_done_be !== 1'b1) begin errs++; $display("FAIL rnd_latency op%0d: got %0d/%b want %0d/1", n, obs_lat, obs_done_be, exp_lat); end
      vectors++; if (obs_fault_le !== flt || obs_fault_be !== flt) begin errs++; $display("FAIL rnd_fault op%0d addr %h size %0d: got %b%b want %b", n, a, sz, obs_fault_le, obs_fault_be, flt); end
      vectors++; if (obs_strobe !== exp_strobe) begin errs++; $display("FAIL rnd_strobe op%0d: got %b want %b", n, obs_strobe, exp_strobe); end
      vectors++; if (obs_rd_le !== exp_rd_le || obs_rd_be !== exp_rd_be) begin errs++; $display("FAIL rnd_rdata op%0d addr %h: got %h/%h want %h/%h", n, a, obs_rd_le, obs_rd_be, exp_rd_le, exp_rd_be); end
      vectors++; if (mem_le[widx] !== ref_le[widx] || mem_be[widx] !== ref_be[widx]) begin errs++; $display("FAIL rnd_mem op%0d word %0d: got %h/%h want %h/%h", n, widx, mem_le[widx], mem_be[widx], ref_le[widx], ref_be[widx]); end
      if (!flt) begin
        vectors++; if (obs_addr !== {24'b0, widx}) begin errs++; $display("FAIL rnd_address op%0d: got %h want %h", n, obs_addr, widx); end
      end
    end
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h77;
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++; if (mwr_le !== 1'b1 || rdy_le !== 1'b0) begin errs++; $display("FAIL abort_in_rmw: got write=%b ready=%b want 1/0", mwr_le, rdy_le); end
    #2 SYS_reset = 1'b1;
    #1;
    vectors++; if ({mwr_le, mwr_be} !== 2'b00) begin errs++; $display("FAIL abort_write_drop: got %b want 00", {mwr_le, mwr_be}); end
    vectors++; if (done_le !== 1'b0 || fault_le !== 1'b0) begin errs++; $display("FAIL abort_done_fault: got %b%b want 00", done_le, fault_le); end
    vectors++; if (rdata_le !== 32'h0 || rdata_be !== 32'h0) begin errs++; $display("FAIL abort_rdata: got %h/%h want 0", rdata_le, rdata_be); end
    @(posedge clk); @(posedge clk); #1;
    SYS_reset = 1'b0;
    reload_ref();
    #1;
    vectors++; if (rdy_le !== 1'b1 || rdy_be !== 1'b1) begin errs++; $display("FAIL abort_ready: got %b%b want 11", rdy_le, rdy_be); end
    vectors++; if (mem_le[12] !== image(12)) begin errs++; $display("FAIL abort_mem: got %h want %h", mem_le[12], image(12)); end
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    vectors++; if (obs_rd_le !== image(12)) begin errs++; $display("FAIL abort_reload_read: got %h want %h", obs_rd_le, image(12)); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_sub_word();
    test_big_endian();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
